async_fifo_rd_stream: RTL and testbench

Downstream read-side adapter for async_fifo, clocked in the rd_clk domain.
- Converts the FIFO's rd_en/rd_data/empty pull interface (data valid RD_LATENCY cycles after an accepted rd_en) into a valid/ready stream.
- Prefetches into a small credit-managed output buffer so one beat per cycle is sustained under arbitrary m_ready stalls.
- Never loses, duplicates or reorders a word.

---
 rtl/async_fifo_pkg.sv | 18 +
 rtl/async_fifo_rd_stream_buf.sv | 73 +++++++
 rtl/async_fifo_rd_stream.sv | 114 +++++++++++
 tb/tb_async_fifo_rd_stream.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared types, parameter bounds and helpers for the async_fifo read-side stream adapter.
package async_fifo_pkg;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;

  typedef logic [31:0] stat_cnt_t;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int clog2_level(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic stat_cnt_t sat_inc(input stat_cnt_t cnt, input logic en);
    return (en && (cnt != '1)) ? cnt + 32'd1 : cnt;
  endfunction

endpackage

// File: rtl/async_fifo_rd_stream_buf.sv
// Circular output buffer for async_fifo_rd_stream: push at tail, pop at head, occupancy level.
module stream_buf
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head,
  output logic [clog2_level(DEPTH)-1:0] level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = clog2_level(DEPTH);
  typedef logic [PW-1:0] ptr_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;

  // Explicit wrap compare so DEPTH need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this storage is a handful of flops and is reset so m_data reads 0 during reset; large RAMs would not be.
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

`ifndef SYNTHESIS
  a_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (level_q == LW'(DEPTH))));
  a_underflow : assert property (@(posedge clk) disable iff (rst)
    !(pop && (level_q == '0)));
`endif

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side adapter turning async_fifo rd_en/rd_data/empty into a credit-managed valid/ready stream.
// Optional stats counters are enabled by defining ASYNC_FIFO_RD_STREAM_STATS_EN.
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fifo_empty,
  output logic                              fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]             fifo_rd_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic [clog2_level(BUF_DEPTH)-1:0] buf_level
`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
  ,
  output stat_cnt_t                         stat_beats,
  output stat_cnt_t                         stat_starve,
  output stat_cnt_t                         stat_stall
`endif
);

  localparam int LW = clog2_level(BUF_DEPTH);
  localparam int CW = LW + 2;

  if ((RD_LATENCY < RD_LATENCY_MIN) || (RD_LATENCY > RD_LATENCY_MAX)) begin : g_bad_latency
    $error("async_fifo_rd_stream: RD_LATENCY must be 1..2");
  end
  if (BUF_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
    $error("async_fifo_rd_stream: BUF_DEPTH must be >= RD_LATENCY+1");
  end

  logic [RD_LATENCY-1:0] infl_q, infl_d;
  logic [CW-1:0]         infl_cnt;
  logic [CW-1:0]         occupancy;
  logic                  push, pop, credit_ok;

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      infl_cnt = infl_cnt + CW'(infl_q[i]);
    end
    pop       = m_valid && m_ready;
    push      = infl_q[RD_LATENCY-1];
    occupancy = CW'(buf_level) + infl_cnt;
    // level + inflight - pop < DEPTH, rearranged so nothing can underflow.
    credit_ok  = occupancy < (CW'(BUF_DEPTH) + CW'(pop));
    fifo_rd_en = !rst && !fifo_empty && credit_ok;
    infl_d     = RD_LATENCY'({infl_q, fifo_rd_en});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_q <= '0;
    end else begin
      infl_q <= infl_d;
    end
  end

  stream_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head      (m_data),
    .level     (buf_level)
  );

  assign m_valid = (buf_level != '0);

`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
  stat_cnt_t beats_q, beats_d;
  stat_cnt_t starve_q, starve_d;
  stat_cnt_t stall_q, stall_d;

  always_comb begin
    beats_d  = sat_inc(beats_q, pop);
    starve_d = sat_inc(starve_q, m_ready && !m_valid);
    stall_d  = sat_inc(stall_q, m_valid && !m_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_q  <= '0;
      starve_q <= '0;
      stall_q  <= '0;
    end else begin
      beats_q  <= beats_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_beats  = beats_q;
  assign stat_starve = starve_q;
  assign stat_stall  = stall_q;
`endif

`ifndef SYNTHESIS
  a_rd_when_empty : assert property (@(posedge clk) disable iff (rst)
    !(fifo_rd_en && fifo_empty));
  a_hold_stable : assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));
`endif

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Self-checking bench for async_fifo_rd_stream: behavioural FIFO model, scoreboard queue and vector table.
module tb_async_fifo_rd_stream;
  import async_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int LAT   = 1;
  localparam int DEPTH = LAT + 1;
  localparam int LW    = clog2_level(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [LW-1:0] buf_level;
`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
  stat_cnt_t     stat_beats, stat_starve, stat_stall;
`endif

  always #5 clk = ~clk;

  async_fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .RD_LATENCY (LAT),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .buf_level    (buf_level)
`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
    ,
    .stat_beats   (stat_beats),
    .stat_starve  (stat_starve),
    .stat_stall   (stat_stall)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural async_fifo read port: registered rd_data, LAT cycles after an accepted rd_en.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  logic          empty_mask = 1'b0;
  logic [DW-1:0] rd_pipe [LAT] = '{default: '0};

  assign fifo_empty   = empty_mask || (wr_cnt == rd_cnt);
  assign fifo_rd_data = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty && (fq.size() != 0)) begin
      rd_pipe[0] <= fq.pop_front();
      rd_cnt     <= rd_cnt + 1;
    end else if (fifo_rd_en) begin
      rd_pipe[0] <= 8'hEE;
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    wr_cnt++;
  endtask

  task automatic flush_all();
    fq.delete();
    exp_q.delete();
    wr_cnt = rd_cnt;
  endtask

  // Monitor: samples 3 time units after each falling edge, 2 before the rising edge.
  int beats = 0;
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      if (fifo_empty) check("rd_en_while_empty", {31'd0, fifo_rd_en}, 32'd0);
      if (m_valid && m_ready) begin
        check("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("beat_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        beats++;
      end
    end
  end

  typedef struct {
    logic          rdy;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [LW-1:0] exp_level;
    logic          exp_rd_en;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats0;
    int written;
    int acc;
    logic [15:0] lfsr;

    tbl[0] = '{1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 8'h01, 2'd1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 8'h02, 2'd1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 8'h03, 2'd1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 8'h04, 2'd1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 8'h00, 2'd0, 1'b0};

    // Test 1: reset with FIFO preloaded, then first-word latency and back-to-back beats.
    @(negedge clk);
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    #3;
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_level", {30'd0, buf_level}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      m_ready = tbl[i].rdy;
      #3;
      check($sformatf("t1_valid[%0d]", i), {31'd0, m_valid}, {31'd0, tbl[i].exp_valid});
      check($sformatf("t1_level[%0d]", i), {30'd0, buf_level}, {30'd0, tbl[i].exp_level});
      check($sformatf("t1_rd_en[%0d]", i), {31'd0, fifo_rd_en}, {31'd0, tbl[i].exp_rd_en});
      if (tbl[i].exp_valid) check($sformatf("t1_data[%0d]", i), {24'd0, m_data}, {24'd0, tbl[i].exp_data});
    end

    // Test 2: long stall with a deep FIFO, then release.
    @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_word(8'h10 + 8'(i));
    #3;
    for (int c = 1; c < 50; c++) begin
      @(negedge clk);
      #3;
      if (c >= 3) begin
        check("t2_level_full", {30'd0, buf_level}, DEPTH);
        check("t2_no_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("t2_head_held", {24'd0, m_data}, 32'h10);
        check("t2_valid", {31'd0, m_valid}, 32'd1);
      end
    end
    @(negedge clk);
    m_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      if (s > 0) @(negedge clk);
      #3;
      check("t2_no_gap", {31'd0, m_valid}, 32'd1);
    end
    @(negedge clk);
    #3;
    check("t2_drained", {31'd0, m_valid}, 32'd0);
    check("t2_scoreboard_empty", exp_q.size(), 32'd0);

    // Test 3: random m_ready against a writer running at 3/5 of the read rate.
    beats0  = beats;
    written = 0;
    acc     = 0;
    lfsr    = 16'hACE1;
    for (int cyc = 0; cyc < 40000 && (beats - beats0) < 5000; cyc++) begin
      @(negedge clk);
      lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      m_ready = lfsr[0];
      acc     = acc + 3;
      if (acc >= 5 && written < 5000) begin
        acc = acc - 5;
        push_word(8'($urandom_range(0, 255)));
        written++;
      end
    end
    check("t3_beats", beats - beats0, 32'd5000);
    check("t3_leftover", exp_q.size(), 32'd0);

    // Test 4: reset mid-burst, then only post-reset words may appear.
    @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'h30 + 8'(i));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    flush_all();
    #3;
    check("t4_rst_valid", {31'd0, m_valid}, 32'd0);
    check("t4_rst_level", {30'd0, buf_level}, 32'd0);
    check("t4_rst_data", {24'd0, m_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #3;
      check("t4_no_stale", {31'd0, m_valid}, 32'd0);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
    #3;
    for (int c = 0; c < 10 && !m_valid; c++) begin
      @(negedge clk);
      #3;
    end
    check("t4_first_valid", {31'd0, m_valid}, 32'd1);
    check("t4_first_data", {24'd0, m_data}, 32'hA0);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    check("t4_drained", exp_q.size(), 32'd0);

    // Test 5: fifo_empty toggling every cycle.
    @(negedge clk);
    for (int i = 0; i < 12; i++) push_word(8'h50 + 8'(i));
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      empty_mask = ~empty_mask;
    end
    @(negedge clk);
    empty_mask = 1'b0;
    check("t5_all_delivered", exp_q.size(), 32'd0);

`ifdef ASYNC_FIFO_RD_STREAM_STATS_EN
    // Test 6: 4 starve cycles, 3 stall cycles, 10 beats.
    @(negedge clk);
    rst     = 1'b1;
    m_ready = 1'b0;
    flush_all();
    @(negedge clk);
    rst     = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(8'h70 + 8'(i));
    repeat (5) @(negedge clk);
    m_ready = 1'b1;
    repeat (10) @(negedge clk);
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("t6_stat_beats", stat_beats, 32'd10);
    check("t6_stat_stall", stat_stall, 32'd3);
    check("t6_stat_starve", stat_starve, 32'd4);
    check("t6_drained", exp_q.size(), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
